sdram_burst_tester: RTL

Parametrised FPGA-to-SDRAM traffic engine. It is the successor to the single-beat pattern writer in the SoC top level. It drives an Avalon-MM master port into the HPS FPGA-to-SDRAM bridge and issues burst writes and/or burst reads of a deterministic pattern, checking read data against that pattern. Control and status inputs/outputs connect to the 16-bit control/status register file; done_o feeds an IRQ line.

---
 rtl/sdram_burst_tester.sv | 328 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sdram_burst_tester.sv
// sdram_burst_tester: Avalon-MM traffic engine that writes a deterministic
// pattern in bursts and/or reads it back in bursts and counts mismatches.
// Optional build macro: SDRAM_TEST_TIMEOUT_EN enables a no-progress watchdog
// that aborts a stalled test after TIMEOUT_CYCLES cycles and raises timeout_o.
module sdram_burst_tester #(
  parameter int DATA_W         = 128,
  parameter int ADDR_W         = 28,
  parameter int BURST_W        = 8,
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [1:0]            mode_i,
  input  logic [ADDR_W-1:0]     base_addr_i,
  input  logic [CNT_W-1:0]      size_i,
  input  logic [BURST_W-1:0]    burst_len_i,
  output logic [ADDR_W-1:0]     avm_address_o,
  output logic [BURST_W-1:0]    avm_burstcount_o,
  output logic                  avm_write_o,
  output logic [DATA_W-1:0]     avm_writedata_o,
  output logic [DATA_W/8-1:0]   avm_byteenable_o,
  output logic                  avm_read_o,
  input  logic [DATA_W-1:0]     avm_readdata_i,
  input  logic                  avm_readdatavalid_i,
  input  logic                  avm_waitrequest_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CNT_W-1:0]      err_cnt_o,
  output logic [ADDR_W-1:0]     first_err_addr_o,
  output logic [CNT_W-1:0]      cycle_cnt_o,
  output logic                  timeout_o
);

  localparam int                HALF_W    = DATA_W / 2;
  localparam int                MAX_BURST = 2 ** (BURST_W - 1);
  localparam logic [BURST_W-1:0] BL_ONE   = BURST_W'(1);
  localparam logic [BURST_W-1:0] BL_MAX   = BURST_W'(MAX_BURST);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0]   CNT_SAT  = {CNT_W{1'b1}};

  if ((DATA_W < 16) || ((DATA_W % 2) != 0) || (BURST_W < 2) || (TIMEOUT_CYCLES < 2)) begin : g_bad_params
    $error("sdram_burst_tester: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_EMPTY,
    S_WR_BURST,
    S_RD_CMD,
    S_RD_DATA,
    S_FIN
  } state_t;

  // Pattern word for a global word index: {~idx, idx} split across the halves.
  function automatic logic [DATA_W-1:0] pattern_f(input logic [CNT_W-1:0] idx);
    logic [HALF_W-1:0] lo;
    lo = HALF_W'(idx);
    return {~lo, lo};
  endfunction

  // Requested burst length with 0 mapped to 1 and oversize clamped.
  function automatic logic [BURST_W-1:0] clamp_len_f(input logic [BURST_W-1:0] bl);
    if (bl == BURST_W'(0)) begin
      return BL_ONE;
    end else if (bl > BL_MAX) begin
      return BL_MAX;
    end else begin
      return bl;
    end
  endfunction

  // Length of the next burst: the configured length, shortened at the tail.
  function automatic logic [BURST_W-1:0] burst_len_f(input logic [CNT_W-1:0] rem,
                                                     input logic [BURST_W-1:0] bl);
    if (rem < CNT_W'(bl)) begin
      return BURST_W'(rem);
    end else begin
      return bl;
    end
  endfunction

  state_t              state_q;
  logic                do_read_q;
  logic [ADDR_W-1:0]   base_q;
  logic [BURST_W-1:0]  blen_q;
  logic [CNT_W-1:0]    rem_q;
  logic [CNT_W-1:0]    idx_q;
  logic [BURST_W-1:0]  beats_q;
  logic [ADDR_W-1:0]   avm_address_q;
  logic [BURST_W-1:0]  avm_burstcount_q;
  logic                avm_write_q;
  logic [DATA_W-1:0]   avm_writedata_q;
  logic                avm_read_q;
  logic                busy_q;
  logic                done_q;
  logic [CNT_W-1:0]    err_cnt_q;
  logic [ADDR_W-1:0]   first_err_addr_q;
  logic [CNT_W-1:0]    cycle_cnt_q;

  logic                wr_accept_d;
  logic                mismatch_d;
  logic [CNT_W-1:0]    rem_dec_d;
  logic [CNT_W-1:0]    idx_inc_d;
  logic [BURST_W-1:0]  next_len_d;
  logic [BURST_W-1:0]  start_len_d;
  logic [BURST_W-1:0]  rd_first_len_d;
  logic [ADDR_W-1:0]   next_addr_d;
  logic [ADDR_W-1:0]   beat_addr_d;

  // Next-burst bookkeeping and read-beat verification, derived from current state.
  always_comb begin
    wr_accept_d    = avm_write_q & ~avm_waitrequest_i;
    mismatch_d     = (state_q == S_RD_DATA) && avm_readdatavalid_i &&
                     (avm_readdata_i != pattern_f(idx_q));
    rem_dec_d      = rem_q - CNT_ONE;
    idx_inc_d      = idx_q + CNT_ONE;
    next_len_d     = burst_len_f(rem_dec_d, blen_q);
    start_len_d    = burst_len_f(size_i, clamp_len_f(burst_len_i));
    rd_first_len_d = burst_len_f(rem_q, blen_q);
    next_addr_d    = avm_address_q + ADDR_W'(avm_burstcount_q);
    beat_addr_d    = base_q + ADDR_W'(idx_q);
  end

`ifdef SDRAM_TEST_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_q;
  logic            timeout_q;
  logic            progress_d;

  // Any write acceptance or returned read beat counts as forward progress.
  always_comb begin
    progress_d = wr_accept_d | avm_readdatavalid_i;
  end
`endif

  // Main sequencer: latches the job, walks write/read bursts, updates status.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q          <= S_IDLE;
      do_read_q        <= 1'b0;
      base_q           <= '0;
      blen_q           <= '0;
      rem_q            <= '0;
      idx_q            <= '0;
      beats_q          <= '0;
      avm_address_q    <= '0;
      avm_burstcount_q <= '0;
      avm_write_q      <= 1'b0;
      avm_writedata_q  <= '0;
      avm_read_q       <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      err_cnt_q        <= '0;
      first_err_addr_q <= '0;
      cycle_cnt_q      <= '0;
`ifdef SDRAM_TEST_TIMEOUT_EN
      wd_q             <= '0;
      timeout_q        <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (busy_q) begin
        cycle_cnt_q <= cycle_cnt_q + CNT_ONE;
      end

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            do_read_q        <= mode_i[1];
            base_q           <= base_addr_i;
            blen_q           <= clamp_len_f(burst_len_i);
            rem_q            <= size_i;
            idx_q            <= '0;
            beats_q          <= start_len_d;
            avm_address_q    <= base_addr_i;
            avm_burstcount_q <= start_len_d;
            busy_q           <= 1'b1;
            err_cnt_q        <= '0;
            first_err_addr_q <= '0;
            cycle_cnt_q      <= '0;
`ifdef SDRAM_TEST_TIMEOUT_EN
            timeout_q        <= 1'b0;
`endif
            if (size_i == CNT_ZERO) begin
              state_q <= S_EMPTY;
            end else if (mode_i == 2'd1) begin
              state_q    <= S_RD_CMD;
              avm_read_q <= 1'b1;
            end else begin
              state_q         <= S_WR_BURST;
              avm_write_q     <= 1'b1;
              avm_writedata_q <= pattern_f(CNT_ZERO);
            end
          end
        end

        S_EMPTY: begin
          state_q <= S_FIN;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end

        S_WR_BURST: begin
          if (wr_accept_d) begin
            idx_q <= idx_inc_d;
            rem_q <= rem_dec_d;
            if (beats_q == BL_ONE) begin
              if (rem_q == CNT_ONE) begin
                avm_write_q <= 1'b0;
                if (do_read_q) begin
                  // Read-back restarts at the base with the first burst length.
                  state_q          <= S_RD_CMD;
                  avm_read_q       <= 1'b1;
                  avm_address_q    <= base_q;
                  avm_burstcount_q <= burst_len_f(idx_inc_d, blen_q);
                  beats_q          <= burst_len_f(idx_inc_d, blen_q);
                  rem_q            <= idx_inc_d;
                  idx_q            <= '0;
                end else begin
                  state_q <= S_FIN;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end
              end else begin
                avm_address_q    <= next_addr_d;
                avm_burstcount_q <= next_len_d;
                beats_q          <= next_len_d;
                avm_writedata_q  <= pattern_f(idx_inc_d);
              end
            end else begin
              beats_q         <= beats_q - BL_ONE;
              avm_writedata_q <= pattern_f(idx_inc_d);
            end
          end
        end

        S_RD_CMD: begin
          if (!avm_waitrequest_i) begin
            avm_read_q <= 1'b0;
            state_q    <= S_RD_DATA;
          end
        end

        S_RD_DATA: begin
          if (avm_readdatavalid_i) begin
            idx_q <= idx_inc_d;
            rem_q <= rem_dec_d;
            if (mismatch_d) begin
              if (err_cnt_q == CNT_ZERO) begin
                first_err_addr_q <= beat_addr_d;
              end
              if (err_cnt_q != CNT_SAT) begin
                err_cnt_q <= err_cnt_q + CNT_ONE;
              end
            end
            if (beats_q == BL_ONE) begin
              if (rem_q == CNT_ONE) begin
                state_q <= S_FIN;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q          <= S_RD_CMD;
                avm_read_q       <= 1'b1;
                avm_address_q    <= next_addr_d;
                avm_burstcount_q <= next_len_d;
                beats_q          <= next_len_d;
              end
            end else begin
              beats_q <= beats_q - BL_ONE;
            end
          end
        end

        S_FIN: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          avm_write_q <= 1'b0;
          avm_read_q  <= 1'b0;
        end
      endcase

`ifdef SDRAM_TEST_TIMEOUT_EN
      // Watchdog: a long run of busy cycles without progress aborts the test.
      if (busy_q && !progress_d) begin
        if (wd_q == WD_LAST) begin
          wd_q        <= '0;
          avm_write_q <= 1'b0;
          avm_read_q  <= 1'b0;
          timeout_q   <= 1'b1;
          state_q     <= S_FIN;
          busy_q      <= 1'b0;
          done_q      <= 1'b1;
        end else begin
          wd_q <= wd_q + WD_W'(1);
        end
      end else begin
        wd_q <= '0;
      end
`endif
    end
  end

  assign avm_address_o    = avm_address_q;
  assign avm_burstcount_o = avm_burstcount_q;
  assign avm_write_o      = avm_write_q;
  assign avm_writedata_o  = avm_writedata_q;
  assign avm_byteenable_o = {(DATA_W/8){1'b1}};
  assign avm_read_o       = avm_read_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign err_cnt_o        = err_cnt_q;
  assign first_err_addr_o = first_err_addr_q;
  assign cycle_cnt_o      = cycle_cnt_q;
`ifdef SDRAM_TEST_TIMEOUT_EN
  assign timeout_o        = timeout_q;
`else
  assign timeout_o        = 1'b0;
`endif

endmodule
